// File: rtl/shake_pkg.sv
// Shared SHAKE definitions: mode encoding, rate sizes, squeeze FSM states
// and small helpers for the optional tail-byte masking
// (enabled by SHAKE_SQUEEZE_TAIL_MASK_EN).
package shake_pkg;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_e;

    localparam int unsigned RATE_W128 = 42;
    localparam int unsigned RATE_W256 = 34;

    typedef enum logic [2:0] {
        SQ_IDLE,
        SQ_WAIT_RDY,
        SQ_READ,
        SQ_PERMUTE,
        SQ_DRAIN,
        SQ_FIN
    } squeeze_state_e;

    // Number of 32-bit rate words for the selected mode.
    function automatic logic [6:0] rate_words(input shake_mode_e m);
        return (m == SHAKE256) ? 7'(RATE_W256) : 7'(RATE_W128);
    endfunction

    // Byte-keep mask for the final word; 0 means the whole word is kept.
    function automatic logic [3:0] tail_keep(input logic [1:0] tail);
        case (tail)
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    // Expand a byte-keep mask into a 32-bit data mask.
    function automatic logic [31:0] keep_to_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

endpackage

// File: rtl/shake_squeeze_fifo.sv
// Two-entry FIFO holding squeezed words and their byte addresses.
// Entry 0 is always the head; push and pop may happen in the same cycle.
module shake_squeeze_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [31:0] i_push_data,
    input  logic [31:0] i_push_addr,
    input  logic        i_pop,
    output logic [31:0] o_head_data,
    output logic [31:0] o_head_addr,
    output logic [1:0]  o_count
);

    logic [31:0] r_data [2];
    logic [31:0] r_addr [2];
    logic [1:0]  r_count;
    logic        w_pop;
    logic        w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    assign o_head_data = r_data[0];
    assign o_head_addr = r_addr[0];
    assign o_count     = r_count;

    // Shift-register storage: pops move entry 1 to the head, pushes fill the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is cleared on reset because its head entry drives out_data/out_addr directly, which must read 0 out of reset.
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= 32'd0;
                r_addr[i] <= 32'd0;
            end
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data[0] <= i_push_data;
                        r_addr[0] <= i_push_addr;
                    end else begin
                        r_data[1] <= i_push_data;
                        r_addr[1] <= i_push_addr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data[0] <= r_data[1];
                    r_addr[0] <= r_addr[1];
                    r_count   <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data[0] <= i_push_data;
                        r_addr[0] <= i_push_addr;
                    end else begin
                        r_data[0] <= r_data[1];
                        r_addr[0] <= r_addr[1];
                        r_data[1] <= i_push_data;
                        r_addr[1] <= i_push_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shake_squeeze.sv
// SHAKE squeeze engine: reads rate words from the sha3 core, streams them
// with a valid/ready handshake and requests permutations between rate blocks.
// Optional tail masking of the last word: define SHAKE_SQUEEZE_TAIL_MASK_EN.
module shake_squeeze
    import shake_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] out_words,
    input  logic             core_ready,
    input  logic [31:0]      core_dout,
    output logic [6:0]       core_addr,
    output logic             core_next,
    output logic [31:0]      out_data,
    output logic [31:0]      out_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef SHAKE_SQUEEZE_TAIL_MASK_EN
    input  logic [1:0]       tail_bytes,
    output logic [3:0]       out_keep,
`endif
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    squeeze_state_e   r_state;
    squeeze_state_e   w_next_state;
    shake_mode_e      r_mode;
    logic [CNT_W-1:0] r_words;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_accepted;
    logic [6:0]       r_word_idx;
    logic             r_inflight;
    logic [31:0]      r_inflight_addr;
    logic [31:0]      r_rd_addr;
    logic             r_perm_first;

    logic [6:0]       w_rate;
    logic             w_issue;
    logic             w_pop;
    logic [1:0]       w_fifo_count;
    logic [2:0]       w_occ;
    logic [31:0]      w_head_data;
    logic [CNT_W-1:0] w_issued_inc;
    logic [CNT_W-1:0] w_accepted_inc;

    assign w_rate         = rate_words(r_mode);
    assign w_issued_inc   = r_issued + ONE;
    assign w_accepted_inc = r_accepted + ONE;
    assign out_valid      = (w_fifo_count != 2'd0);
    assign w_pop          = out_valid && out_ready;
    // FIFO occupancy seen by the issue rule: stored + in flight - leaving now.
    assign w_occ          = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign core_addr      = r_word_idx;

    shake_squeeze_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (core_dout),
        .i_push_addr (r_inflight_addr),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_head_addr (out_addr),
        .o_count     (w_fifo_count)
    );

`ifdef SHAKE_SQUEEZE_TAIL_MASK_EN
    logic [1:0] r_tail;
    logic       w_is_last;

    assign w_is_last = out_valid && (w_accepted_inc == r_words);
    assign out_keep  = w_is_last ? tail_keep(r_tail) : 4'hF;
    assign out_data  = w_head_data & keep_to_mask(out_keep);

    // Tail byte count is captured with the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tail <= 2'd0;
        end else if ((r_state == SQ_IDLE) && start) begin
            r_tail <= tail_bytes;
        end
    end
`else
    assign out_data = w_head_data;
`endif

    // Next-state, read issue and control outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_issue      = 1'b0;
        core_next    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            SQ_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = SQ_WAIT_RDY;
            end
            SQ_WAIT_RDY: begin
                if (core_ready) w_next_state = (r_words == '0) ? SQ_FIN : SQ_READ;
            end
            SQ_READ: begin
                if ((r_issued != r_words) && (w_occ < 3'd2)) begin
                    w_issue = 1'b1;
                    if (w_issued_inc == r_words)              w_next_state = SQ_DRAIN;
                    else if (r_word_idx == (w_rate - 7'd1))   w_next_state = SQ_PERMUTE;
                end
            end
            SQ_PERMUTE: begin
                core_next = r_perm_first;
                if (!r_perm_first && core_ready) w_next_state = SQ_READ;
            end
            SQ_DRAIN: begin
                if (w_pop && (w_accepted_inc == r_words)) w_next_state = SQ_FIN;
            end
            SQ_FIN: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_next_state = SQ_IDLE;
            end
            default: w_next_state = SQ_IDLE;
        endcase
    end

    // State register, request capture, counters and read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= SQ_IDLE;
            r_mode          <= SHAKE128;
            r_words         <= '0;
            r_issued        <= '0;
            r_accepted      <= '0;
            r_word_idx      <= 7'd0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= 32'd0;
            r_rd_addr       <= 32'd0;
            r_perm_first    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_next_state;
            r_inflight   <= w_issue;
            r_perm_first <= (r_state != SQ_PERMUTE);
            if ((r_state == SQ_IDLE) && start) begin
                r_mode     <= shake_mode_e'(mode);
                r_words    <= out_words;
                r_issued   <= '0;
                r_accepted <= '0;
                r_word_idx <= 7'd0;
                r_rd_addr  <= 32'd0;
            end else begin
                if (w_issue) begin
                    r_issued        <= w_issued_inc;
                    r_inflight_addr <= r_rd_addr;
                    r_rd_addr       <= r_rd_addr + 32'd4;
                    if (r_word_idx != (w_rate - 7'd1)) r_word_idx <= r_word_idx + 7'd1;
                end
                if ((r_state == SQ_PERMUTE) && (w_next_state == SQ_READ)) r_word_idx <= 7'd0;
                if (w_pop) r_accepted <= w_accepted_inc;
            end
        end
    end

endmodule
